// File: rtl/cpen391_group5_timer_driver.sv
// Avalon-MM initiator that programs, services and samples the interval timer s1 port.
// Bus outputs are registered from the next state, so each bus state shows its cycle on the bus.
module cpen391_group5_timer_driver #(
  parameter int unsigned READ_LATENCY = 1,
  parameter logic        IRQ_ENABLE   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        snap_req,
  input  logic [31:0] period,
  input  logic        continuous,
  input  logic        irq_in,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  output logic        busy,
  output logic        tick_pulse,
  output logic [15:0] tick_count,
  output logic [31:0] snapshot,
  output logic        snap_valid
);

  localparam int unsigned CW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [CW-1:0] LAT = CW'(READ_LATENCY);

  typedef enum logic [3:0] {
    IDLE, WR_PERL, WR_PERH, WR_CTRL, RUN,
    CLR_STAT, WR_STOP, WR_SNAP, RD_SNAPL, RD_SNAPH
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [31:0]   per_q, per_d;
  logic          cont_q, cont_d;
  logic          irq_mask;
  logic [15:0]   snap_lo;
  logic          accept_start, cap_lo, cap_hi;
  logic          cs_d, wr_n_d;
  logic [2:0]    addr_d;
  logic [15:0]   wdata_d;

  assign busy = (state != IDLE);

  always_comb begin
    state_d      = state;
    cnt_d        = '0;
    accept_start = 1'b0;
    cap_lo       = 1'b0;
    cap_hi       = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept_start = 1'b1;
        state_d      = WR_PERL;
      end
      WR_PERL:  state_d = WR_PERH;
      WR_PERH:  state_d = WR_CTRL;
      WR_CTRL:  state_d = RUN;
      RUN: begin
        if (irq_in && !irq_mask) state_d = CLR_STAT;
        else if (stop)           state_d = WR_STOP;
        else if (snap_req)       state_d = WR_SNAP;
      end
      CLR_STAT: state_d = cont_q ? RUN : IDLE;
      WR_STOP:  state_d = IDLE;
      WR_SNAP:  state_d = RD_SNAPL;
      // Read strobe is the first cycle only; capture after READ_LATENCY wait cycles.
      RD_SNAPL: if (cnt == LAT) begin
        cap_lo  = 1'b1;
        state_d = RD_SNAPH;
      end else cnt_d = cnt + CW'(1);
      RD_SNAPH: if (cnt == LAT) begin
        cap_hi  = 1'b1;
        state_d = RUN;
      end else cnt_d = cnt + CW'(1);
      default:  state_d = IDLE;
    endcase

    per_d  = accept_start ? period : per_q;
    cont_d = accept_start ? continuous : cont_q;

    cs_d    = 1'b0;
    wr_n_d  = 1'b1;
    addr_d  = '0;
    wdata_d = '0;
    case (state_d)
      WR_PERL:  begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd2; wdata_d = per_d[15:0]; end
      WR_PERH:  begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd3; wdata_d = per_d[31:16]; end
      WR_CTRL:  begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd1; wdata_d = {12'b0, 2'b01, cont_d, IRQ_ENABLE}; end
      CLR_STAT: begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd0; end
      WR_STOP:  begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd1; wdata_d = {12'b0, 2'b10, cont_d, IRQ_ENABLE}; end
      WR_SNAP:  begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd4; end
      RD_SNAPL: begin cs_d = (cnt_d == '0); addr_d = 3'd4; end
      RD_SNAPH: begin cs_d = (cnt_d == '0); addr_d = 3'd5; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      per_q          <= '0;
      cont_q         <= 1'b0;
      irq_mask       <= 1'b0;
      snap_lo        <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      tick_pulse     <= 1'b0;
      tick_count     <= '0;
      snapshot       <= '0;
      snap_valid     <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      per_q          <= per_d;
      cont_q         <= cont_d;
      // The cleared irq may still read high in the first RUN cycle after CLR_STAT.
      irq_mask       <= (state == CLR_STAT);
      avm_chipselect <= cs_d;
      avm_write_n    <= wr_n_d;
      avm_address    <= addr_d;
      avm_writedata  <= wdata_d;
      tick_pulse     <= (state_d == CLR_STAT);
      if (accept_start)             tick_count <= '0;
      else if (state_d == CLR_STAT) tick_count <= tick_count + 16'd1;
      if (cap_lo) snap_lo <= avm_readdata;
      if (cap_hi) snapshot <= {avm_readdata, snap_lo};
      snap_valid     <= cap_hi;
    end
  end

endmodule
